mode_counter: RTL

Parametrised, synchronous counter that generalises the team's fixed 4-bit free-running counter. It supports configurable width and terminal value, up / down / ping-pong / hold modes, count enable and synchronous load. It also provides a one-cycle terminal-count pulse and a saturating wrap tally. It is intended as the standard timing/sequence source behind `top`-level designs, and as the first fully parameterised block on the hackathon test bench.

---
 rtl/mode_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - parameterised up/down/ping-pong/hold counter with terminal pulse and wrap tally
module mode_counter #(
    parameter int              WIDTH  = 4,
    parameter longint unsigned MAX    = (64'd1 << WIDTH) - 64'd1,
    parameter int              WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  q,
    output logic              dir,
    output logic              tc,
    output logic [WRAP_W-1:0] wraps
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mode_counter: WIDTH must be in 2..32");
    end
    if (MAX < 64'd1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("mode_counter: MAX must be in 1..2**WIDTH-1");
    end
    if (WRAP_W < 1) begin : g_bad_wrap_w
        $error("mode_counter: WRAP_W must be at least 1");
    end

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0]  MAX_V    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]  ZERO     = '0;
    localparam logic [WRAP_W-1:0] WRAP_SAT = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    logic [WIDTH-1:0]  q_q, q_d;
    logic              dir_q, dir_d;
    logic              tc_q, tc_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              wrap_event;

    always_comb begin
        q_d        = q_q;
        dir_d      = dir_q;
        tc_d       = 1'b0;
        wraps_d    = wraps_q;
        wrap_event = 1'b0;

        if (load) begin
            q_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_UP: begin
                    dir_d = 1'b1;
                    if (q_q == MAX_V) begin
                        q_d        = ZERO;
                        wrap_event = 1'b1;
                    end else begin
                        q_d = q_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (q_q == ZERO) begin
                        q_d        = MAX_V;
                        wrap_event = 1'b1;
                    end else begin
                        q_d = q_q - ONE;
                    end
                end
                MODE_PING: begin
                    // With a two-value range every step lands on an end, so every step is a turn.
                    if (MAX_V == ONE) begin
                        q_d        = (q_q == ZERO) ? ONE : ZERO;
                        dir_d      = (q_q == ZERO);
                        wrap_event = 1'b1;
                    end else if (dir_q && q_q == MAX_V) begin
                        q_d        = MAX_V - ONE;
                        dir_d      = 1'b0;
                        wrap_event = 1'b1;
                    end else if (!dir_q && q_q == ZERO) begin
                        q_d        = ONE;
                        dir_d      = 1'b1;
                        wrap_event = 1'b1;
                    end else begin
                        q_d = dir_q ? (q_q + ONE) : (q_q - ONE);
                    end
                end
                default: begin
                end
            endcase
        end

        tc_d = wrap_event;
        if (wrap_event && wraps_q != WRAP_SAT) begin
            wraps_d = wraps_q + WRAP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= '0;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
            wraps_q <= '0;
        end else begin
            q_q     <= q_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            wraps_q <= wraps_d;
        end
    end

    assign q     = q_q;
    assign dir   = dir_q;
    assign tc    = tc_q;
    assign wraps = wraps_q;

endmodule
